// File: rtl/skinny_ctrl_pkg.sv
// Shared types and widths for the masked SKINNY round controller.
package skinny_ctrl_pkg;

  localparam int STAGE_W = 2;
  localparam int ROUND_W = 6;
  // Width of one refresh word, matching the coordinate-function r bus.
  localparam int RAND_W  = 72;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/skinny_stage_round_cnt.sv
// Stage/round counter pair for the masked SKINNY sequencer.
module skinny_stage_round_cnt
  import skinny_ctrl_pkg::*;
#(
  parameter int NUM_ROUNDS = 32,
  parameter int NUM_STAGES = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_adv,
  input  logic               i_clr,
  output logic [STAGE_W-1:0] o_stage,
  output logic [ROUND_W-1:0] o_round,
  output logic               o_wrap,
  output logic               o_last
);

  logic [STAGE_W-1:0] r_stage;
  logic [ROUND_W-1:0] r_round;

  assign o_stage = r_stage;
  assign o_round = r_round;
  assign o_wrap  = (r_stage == STAGE_W'(NUM_STAGES - 1));
  assign o_last  = (r_round == ROUND_W'(NUM_ROUNDS - 1));

  // The final advance wraps the stage but leaves round parked on the last index.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stage <= '0;
      r_round <= '0;
    end else if (i_clr) begin
      r_stage <= '0;
      r_round <= '0;
    end else if (i_adv) begin
      if (o_wrap) begin
        r_stage <= '0;
        if (!o_last) r_round <= r_round + ROUND_W'(1);
      end else begin
        r_stage <= r_stage + STAGE_W'(1);
      end
    end
  end

endmodule

// File: rtl/skinny_masked_round_ctrl.sv
// Round/stage sequencer for the 4-stage second-order masked SKINNY datapath.
// Optional abort input enabled by defining SKINNY_CTRL_ABORT_EN.
module skinny_masked_round_ctrl
  import skinny_ctrl_pkg::*;
#(
  parameter int NUM_ROUNDS = 32,
  parameter int NUM_STAGES = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
`ifdef SKINNY_CTRL_ABORT_EN
  input  logic               i_abort,
`endif
  input  logic               i_rand_valid,
  output logic               o_rand_ack,
  output logic               o_sel_load,
  output logic               o_en_state,
  output logic               o_en_key,
  output logic [STAGE_W-1:0] o_stage,
  output logic [ROUND_W-1:0] o_round,
  output logic               o_last_round,
  output logic               o_busy,
  output logic               o_done
);

  ctrl_state_e r_state;
  logic        r_sel_load;
  logic        r_busy;
  logic        r_done;
  logic        w_abort;
  logic        w_adv;
  logic        w_clr;
  logic        w_wrap;
  logic        w_last;

`ifdef SKINNY_CTRL_ABORT_EN
  assign w_abort = i_abort & ((r_state == LOAD) | (r_state == RUN));
`else
  assign w_abort = 1'b0;
`endif

  // One PRNG word is consumed per stage advance, never while stalled or aborting.
  assign w_adv = (r_state == RUN) & i_rand_valid & ~w_abort;
  assign w_clr = (r_state == LOAD) | (r_state == DONE) | w_abort;

  assign o_rand_ack   = w_adv;
  assign o_en_state   = ((r_state == LOAD) & ~w_abort) | w_adv;
  assign o_en_key     = w_adv & w_wrap;
  assign o_last_round = w_last;
  assign o_sel_load   = r_sel_load;
  assign o_busy       = r_busy;
  assign o_done       = r_done;

  skinny_stage_round_cnt #(
    .NUM_ROUNDS (NUM_ROUNDS),
    .NUM_STAGES (NUM_STAGES)
  ) u_cnt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_adv   (w_adv),
    .i_clr   (w_clr),
    .o_stage (o_stage),
    .o_round (o_round),
    .o_wrap  (w_wrap),
    .o_last  (w_last)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_sel_load <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state    <= LOAD;
            r_sel_load <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        LOAD: begin
          r_sel_load <= 1'b0;
          if (w_abort) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state <= RUN;
          end
        end
        RUN: begin
          if (w_abort) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (w_adv & w_wrap & w_last) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state    <= IDLE;
          r_sel_load <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
